// File: rtl/cmplx_mac_pipe_if.sv
// Beat/result bus of cmplx_mac_pipe: operand beat in, formatted complex result out.
// Handshake: a beat moves on a rising edge when in_valid && in_ready, a result moves when out_valid && out_ready; valid never waits on ready.
interface cmplx_mac_pipe_if #(
  parameter int WIDTH = 13
) ();
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] a_re;
  logic signed [WIDTH-1:0] a_im;
  logic signed [WIDTH-1:0] b_re;
  logic signed [WIDTH-1:0] b_im;
  logic                    conj_b;
  logic                    acc_en;
  logic                    acc_last;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_re;
  logic signed [WIDTH-1:0] out_im;
  logic                    out_sat;
  logic                    out_forced;

  modport master (
    output in_valid, a_re, a_im, b_re, b_im, conj_b, acc_en, acc_last, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_sat, out_forced
  );

  modport slave (
    input  in_valid, a_re, a_im, b_re, b_im, conj_b, acc_en, acc_last, out_ready,
    output in_ready, out_valid, out_re, out_im, out_sat, out_forced
  );
endinterface

// File: rtl/cmplx_mac_pipe.sv
// Pipelined complex multiply / multiply-accumulate with conj(b), burst accumulation,
// truncate or round-half-away formatting and saturation. Whole pipe stalls on out backpressure.
module cmplx_mac_pipe #(
  parameter int WIDTH = 13,
  parameter int FRAC  = 8,
  parameter int ROUND = 0,
  parameter int GUARD = 4
) (
  input logic             clk,
  input logic             rst_n,
  cmplx_mac_pipe_if.slave bus
);
  localparam int PW = 2 * WIDTH + 1;
  localparam int AW = PW + GUARD;
  localparam int FW = AW + 1;
  localparam logic [GUARD:0]        CNT_MAX = {1'b1, {GUARD{1'b0}}};
  localparam logic signed [FW-1:0] ONE  = FW'(1);
  localparam logic signed [FW-1:0] HALF = FW'(2 ** (FRAC - 1));
  localparam logic signed [FW-1:0] MAXV = FW'(2 ** (WIDTH - 1) - 1);
  localparam logic signed [FW-1:0] MINV = -MAXV - ONE;

  logic en;
  logic out_valid_q;
  assign en = !out_valid_q || bus.out_ready;
  assign bus.in_ready = en;

  // Operands are captured first so the multipliers see registered inputs.
  logic                    v0_q, conj0_q, acc_en0_q, acc_last0_q;
  logic signed [WIDTH-1:0] ar0_q, ai0_q, br0_q, bi0_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q <= 1'b0; conj0_q <= 1'b0; acc_en0_q <= 1'b0; acc_last0_q <= 1'b0;
      ar0_q <= '0; ai0_q <= '0; br0_q <= '0; bi0_q <= '0;
    end else if (en) begin
      v0_q        <= bus.in_valid;
      conj0_q     <= bus.conj_b;
      acc_en0_q   <= bus.acc_en;
      acc_last0_q <= bus.acc_en && bus.acc_last;
      ar0_q <= bus.a_re; ai0_q <= bus.a_im; br0_q <= bus.b_re; bi0_q <= bus.b_im;
    end
  end

  // b_im is widened before negation so that -(-2^(WIDTH-1)) stays positive.
  logic signed [PW-1:0] ar_x, ai_x, br_x, bi_x, bi_e;
  assign ar_x = PW'(ar0_q);
  assign ai_x = PW'(ai0_q);
  assign br_x = PW'(br0_q);
  assign bi_x = PW'(bi0_q);
  assign bi_e = conj0_q ? -bi_x : bi_x;

  logic                 v1_q, acc_en1_q, acc_last1_q;
  logic signed [PW-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0; acc_en1_q <= 1'b0; acc_last1_q <= 1'b0;
      p_rr_q <= '0; p_ii_q <= '0; p_ri_q <= '0; p_ir_q <= '0;
    end else if (en) begin
      v1_q        <= v0_q;
      acc_en1_q   <= acc_en0_q;
      acc_last1_q <= acc_last0_q;
      p_rr_q <= ar_x * br_x;
      p_ii_q <= ai_x * bi_e;
      p_ri_q <= ar_x * bi_e;
      p_ir_q <= ai_x * br_x;
    end
  end

  logic signed [PW-1:0] sum_re, sum_im;
  logic signed [AW-1:0] acc_re_q, acc_im_q, acc_re_d, acc_im_d, acc_sum_re, acc_sum_im;
  logic signed [AW-1:0] s2_re_q, s2_im_q, s2_re_d, s2_im_d;
  logic [GUARD:0]       cnt_q, cnt_d, cnt_inc;
  logic                 v2_q, v2_d, forced2_q, forced2_d;

  assign sum_re     = p_rr_q - p_ii_q;
  assign sum_im     = p_ri_q + p_ir_q;
  assign acc_sum_re = acc_re_q + AW'(sum_re);
  assign acc_sum_im = acc_im_q + AW'(sum_im);
  assign cnt_inc    = cnt_q + 1'b1;

  // Plain beats bypass the accumulator, so they can be interleaved into a burst.
  always_comb begin
    acc_re_d  = acc_re_q;
    acc_im_d  = acc_im_q;
    cnt_d     = cnt_q;
    v2_d      = 1'b0;
    s2_re_d   = s2_re_q;
    s2_im_d   = s2_im_q;
    forced2_d = forced2_q;
    if (v1_q) begin
      if (!acc_en1_q) begin
        v2_d      = 1'b1;
        s2_re_d   = AW'(sum_re);
        s2_im_d   = AW'(sum_im);
        forced2_d = 1'b0;
      end else if (acc_last1_q || cnt_inc == CNT_MAX) begin
        v2_d      = 1'b1;
        s2_re_d   = acc_sum_re;
        s2_im_d   = acc_sum_im;
        forced2_d = !acc_last1_q;
        acc_re_d  = '0;
        acc_im_d  = '0;
        cnt_d     = '0;
      end else begin
        acc_re_d = acc_sum_re;
        acc_im_d = acc_sum_im;
        cnt_d    = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q <= 1'b0; forced2_q <= 1'b0; s2_re_q <= '0; s2_im_q <= '0;
      acc_re_q <= '0; acc_im_q <= '0; cnt_q <= '0;
    end else if (en) begin
      v2_q <= v2_d; forced2_q <= forced2_d; s2_re_q <= s2_re_d; s2_im_q <= s2_im_d;
      acc_re_q <= acc_re_d; acc_im_q <= acc_im_d; cnt_q <= cnt_d;
    end
  end

  // Returns {saturated, value}; one guard bit above AW keeps the rounding add exact.
  function automatic logic [WIDTH:0] fmt(input logic signed [AW-1:0] x);
    logic signed [FW-1:0] xe, sh;
    logic                 sat;
    logic [WIDTH-1:0]     val;
    xe = FW'(x);
    if (ROUND == 0) begin
      sh = xe >>> FRAC;
      if (x[AW-1] && (x[FRAC-1:0] != '0)) sh = sh + ONE;
    end else if (x[AW-1]) begin
      sh = (xe + HALF - ONE) >>> FRAC;
    end else begin
      sh = (xe + HALF) >>> FRAC;
    end
    sat = 1'b1;
    if (sh > MAXV)      val = MAXV[WIDTH-1:0];
    else if (sh < MINV) val = MINV[WIDTH-1:0];
    else begin
      sat = 1'b0;
      val = sh[WIDTH-1:0];
    end
    return {sat, val};
  endfunction

  logic [WIDTH:0]   fmt_re, fmt_im;
  logic [WIDTH-1:0] out_re_q, out_im_q;
  logic             out_sat_q, out_forced_q;
  assign fmt_re = fmt(s2_re_q);
  assign fmt_im = fmt(s2_im_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0; out_re_q <= '0; out_im_q <= '0;
      out_sat_q <= 1'b0; out_forced_q <= 1'b0;
    end else if (en) begin
      out_valid_q <= v2_q;
      if (v2_q) begin
        out_re_q     <= fmt_re[WIDTH-1:0];
        out_im_q     <= fmt_im[WIDTH-1:0];
        out_sat_q    <= fmt_re[WIDTH] || fmt_im[WIDTH];
        out_forced_q <= forced2_q;
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_re     = out_re_q;
  assign bus.out_im     = out_im_q;
  assign bus.out_sat    = out_sat_q;
  assign bus.out_forced = out_forced_q;
endmodule

// File: tb/tb_cmplx_mac_pipe.sv
// Bench for cmplx_mac_pipe: a truncating and a rounding instance share one stimulus stream;
// an arithmetic model feeds the expected queue checked on every result handshake.
module tb_cmplx_mac_pipe;
  localparam int WIDTH = 13;
  localparam int FRAC  = 8;
  localparam int GUARD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cmplx_mac_pipe_if #(.WIDTH(WIDTH)) if0 ();
  cmplx_mac_pipe_if #(.WIDTH(WIDTH)) if1 ();

  cmplx_mac_pipe #(.WIDTH(WIDTH), .FRAC(FRAC), .ROUND(0), .GUARD(GUARD)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  cmplx_mac_pipe #(.WIDTH(WIDTH), .FRAC(FRAC), .ROUND(1), .GUARD(GUARD)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));

  assign if1.in_valid  = if0.in_valid;
  assign if1.a_re      = if0.a_re;
  assign if1.a_im      = if0.a_im;
  assign if1.b_re      = if0.b_re;
  assign if1.b_im      = if0.b_im;
  assign if1.conj_b    = if0.conj_b;
  assign if1.acc_en    = if0.acc_en;
  assign if1.acc_last  = if0.acc_last;
  assign if1.out_ready = if0.out_ready;

  typedef struct packed {
    logic signed [WIDTH-1:0] re0, im0, re1, im1;
    logic sat0, sat1, forced;
  } exp_t;

  exp_t   exp_q[$];
  int     checks = 0;
  int     failures = 0;
  longint m_acc_re = 0;
  longint m_acc_im = 0;
  int     m_cnt = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [WIDTH-1:0] m_fmt(input longint x, input int rnd, output logic sat);
    longint d, lim, q;
    d   = longint'(1) << FRAC;
    lim = longint'(1) << (WIDTH - 1);
    if (rnd == 0)    q = x / d;
    else if (x >= 0) q = (x + d / 2) / d;
    else             q = -((-x + d / 2) / d);
    sat = 1'b0;
    if (q > lim - 1) begin q = lim - 1; sat = 1'b1; end
    else if (q < -lim) begin q = -lim; sat = 1'b1; end
    return q[WIDTH-1:0];
  endfunction

  task automatic model_push(input longint re, input longint im, input logic forced);
    exp_t e;
    logic sr, si;
    e.re0 = m_fmt(re, 0, sr);
    e.im0 = m_fmt(im, 0, si);
    e.sat0 = sr | si;
    e.re1 = m_fmt(re, 1, sr);
    e.im1 = m_fmt(im, 1, si);
    e.sat1 = sr | si;
    e.forced = forced;
    exp_q.push_back(e);
  endtask

  task automatic model_accept(input int ar, input int ai, input int br, input int bi,
                              input logic conj, input logic ae, input logic al);
    longint bie, re, im;
    bie = conj ? -longint'(bi) : longint'(bi);
    re  = longint'(ar) * br - longint'(ai) * bie;
    im  = longint'(ar) * bie + longint'(ai) * br;
    if (!ae) begin
      model_push(re, im, 1'b0);
    end else begin
      m_acc_re += re;
      m_acc_im += im;
      m_cnt++;
      if (al || m_cnt == (1 << GUARD)) begin
        model_push(m_acc_re, m_acc_im, !al);
        m_acc_re = 0;
        m_acc_im = 0;
        m_cnt = 0;
      end
    end
  endtask

  task automatic set_beat(input int ar, input int ai, input int br, input int bi,
                          input logic conj, input logic ae, input logic al);
    if0.a_re = ar[WIDTH-1:0];
    if0.a_im = ai[WIDTH-1:0];
    if0.b_re = br[WIDTH-1:0];
    if0.b_im = bi[WIDTH-1:0];
    if0.conj_b = conj;
    if0.acc_en = ae;
    if0.acc_last = al;
    if0.in_valid = 1'b1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int ar, input int ai, input int br, input int bi,
                      input logic conj, input logic ae, input logic al);
    int n;
    n = 0;
    set_beat(ar, ai, br, bi, conj, ae, al);
    @(negedge clk);
    while (if0.in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("send_in_ready", 32'(if0.in_ready), 1);
    @(posedge clk);
    model_accept(ar, ai, br, bi, conj, ae, al);
    #1;
    if0.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_valid0"}, 32'(if0.out_valid), 0);
    chk({tag, "_re0"}, 32'($signed(if0.out_re)), 0);
    chk({tag, "_im0"}, 32'($signed(if0.out_im)), 0);
    chk({tag, "_sat0"}, 32'(if0.out_sat), 0);
    chk({tag, "_forced0"}, 32'(if0.out_forced), 0);
    chk({tag, "_valid1"}, 32'(if1.out_valid), 0);
    chk({tag, "_re1"}, 32'($signed(if1.out_re)), 0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && if0.out_valid === 1'b1 && if0.out_ready === 1'b1) begin
      chk("pending_expected", 32'(exp_q.size() != 0), 1);
      chk("valid_lockstep", 32'(if1.out_valid), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("re_trunc", 32'($signed(if0.out_re)), 32'(e.re0));
        chk("im_trunc", 32'($signed(if0.out_im)), 32'(e.im0));
        chk("sat_trunc", 32'(if0.out_sat), 32'(e.sat0));
        chk("forced_trunc", 32'(if0.out_forced), 32'(e.forced));
        chk("re_round", 32'($signed(if1.out_re)), 32'(e.re1));
        chk("im_round", 32'($signed(if1.out_im)), 32'(e.im1));
        chk("sat_round", 32'(if1.out_sat), 32'(e.sat1));
        chk("forced_round", 32'(if1.out_forced), 32'(e.forced));
      end
    end
  end

  int br_ar[8], br_ai[8], br_br[8], br_bi[8];
  logic br_cj[8];
  logic signed [WIDTH-1:0] s_re, s_im;
  logic s_sat, s_forced;

  initial begin
    if0.in_valid = 1'b0;
    if0.a_re = '0; if0.a_im = '0; if0.b_re = '0; if0.b_im = '0;
    if0.conj_b = 1'b0; if0.acc_en = 1'b0; if0.acc_last = 1'b0;
    if0.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", 32'(if0.in_ready), 1);
    @(posedge clk);
    #1;

    // Basic multiply with exact latency
    send(384, 128, 256, -256, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      chk("latency_idle", 32'(if0.out_valid), 0);
      @(posedge clk);
      #1;
    end
    chk("latency_valid", 32'(if0.out_valid), 1);
    chk("basic_re", 32'($signed(if0.out_re)), 512);
    chk("basic_im", 32'($signed(if0.out_im)), -256);
    wait_drain();
    @(posedge clk);
    #1;

    // Conjugate, rounding, saturation
    send(384, 128, 256, -256, 1'b1, 1'b0, 1'b0);
    send(-128, 0, 1, 0, 1'b0, 1'b0, 1'b0);
    send(384, 0, 1, 0, 1'b0, 1'b0, 1'b0);
    send(4095, 0, 4095, 0, 1'b0, 1'b0, 1'b0);
    send(-4096, 0, 4095, 0, 1'b0, 1'b0, 1'b0);
    send(1, 0, 0, -4096, 1'b1, 1'b0, 1'b0);
    send(256, 0, 0, -4096, 1'b1, 1'b0, 1'b0);
    send(-4096, -4096, -4096, -4096, 1'b1, 1'b0, 1'b0);
    send(-300, 77, 512, -9, 1'b0, 1'b0, 1'b1);
    wait_drain();
    @(posedge clk);
    #1;

    // Accumulation: terminated burst, interleaved plain beat, forced burst, clear check
    for (int i = 0; i < 4; i++) send(256, 0, 256, 0, 1'b0, 1'b1, i == 3);
    send(256, 0, 256, 0, 1'b0, 1'b1, 1'b0);
    send(100, -50, 30, 70, 1'b1, 1'b0, 1'b0);
    send(256, 0, 256, 0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) send(16, 0, 256, 0, 1'b0, 1'b1, 1'b0);
    send(256, 0, 256, 0, 1'b0, 1'b1, 1'b1);
    wait_drain();
    @(posedge clk);
    #1;

    // Backpressure mid-stream
    for (int i = 0; i < 8; i++) begin
      br_ar[i] = int'($urandom_range(0, 8191)) - 4096;
      br_ai[i] = int'($urandom_range(0, 8191)) - 4096;
      br_br[i] = int'($urandom_range(0, 8191)) - 4096;
      br_bi[i] = int'($urandom_range(0, 8191)) - 4096;
      br_cj[i] = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 4; i++)
      send(br_ar[i], br_ai[i], br_br[i], br_bi[i], br_cj[i], 1'b0, 1'b0);
    set_beat(br_ar[4], br_ai[4], br_br[4], br_bi[4], br_cj[4], 1'b0, 1'b0);
    if0.out_ready = 1'b0;
    @(negedge clk);
    chk("stall_out_valid", 32'(if0.out_valid), 1);
    s_re = if0.out_re; s_im = if0.out_im; s_sat = if0.out_sat; s_forced = if0.out_forced;
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(if0.in_ready), 0);
      chk("stall_re_stable", 32'($signed(if0.out_re)), 32'(s_re));
      chk("stall_im_stable", 32'($signed(if0.out_im)), 32'(s_im));
      chk("stall_sat_stable", 32'(if0.out_sat), 32'(s_sat));
      chk("stall_forced_stable", 32'(if0.out_forced), 32'(s_forced));
    end
    @(posedge clk);
    #1;
    if0.out_ready = 1'b1;
    for (int i = 4; i < 8; i++)
      send(br_ar[i], br_ai[i], br_br[i], br_bi[i], br_cj[i], 1'b0, 1'b0);
    wait_drain();
    @(posedge clk);
    #1;

    // Asynchronous reset mid-burst discards the burst and the in-flight result
    send(256, 0, 256, 0, 1'b0, 1'b0, 1'b0);
    send(256, 0, 256, 0, 1'b0, 1'b1, 1'b0);
    send(256, 0, 256, 0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("pre_reset_valid", 32'(if0.out_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk_outputs_zero("async_reset");
    exp_q.delete();
    m_acc_re = 0;
    m_acc_im = 0;
    m_cnt = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(256, 0, 256, 0, 1'b0, 1'b1, 1'b1);
    wait_drain();
    repeat (10) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cmplx_mac_pipe.md
# cmplx_mac_pipe

Pipelined, parametrised complex multiplier / multiply-accumulator for the MIMO-OFDM datapath. It replaces the combinational 13-bit complex multiply with a 3-stage registered pipeline that adds:
- valid/ready flow control;
- optional conjugation of operand b;
- optional accumulation over a burst (channel-estimate dot products, equaliser taps);
- selectable truncate-toward-zero or round-half-away output formatting;
- saturation with a flag.

## Interface
Parameters:
- WIDTH, 13, signed fixed-point word width of all operands and results
- FRAC, 8, fraction bits (Q(WIDTH-FRAC).FRAC)
- ROUND, 0, 0 = truncate toward zero (legacy behaviour), 1 = round half away from zero
- GUARD, 4, accumulator guard bits; max burst length 2^GUARD terms

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- a_re, a_im, b_re, b_im  in  WIDTH each  signed operands
- conj_b  in  1  use conj(b) = b_re - j·b_im
- acc_en  in  1  beat belongs to an accumulation burst
- acc_last  in  1  final beat of the burst (ignored when acc_en=0)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_re, out_im  out  WIDTH each  signed result
- out_sat  out  1  either component saturated
- out_forced  out  1  burst terminated by the GUARD limit, not by acc_last

## Operation
- Clock and reset: single clock domain, clk. Reset is asynchronous and active-low on rst_n.
- Accept: a beat is accepted on a rising edge with in_valid && in_ready.
- S1 register:
  - 4 products, each 2·WIDTH bits signed.
  - b_im is negated first when conj_b is set. Negating −2^(WIDTH-1) produces +2^(WIDTH-1); the product path must be WIDTH+1 bits wide for the b_im operand so this value is carried exactly.
  - Also registers the valid, acc_en, and acc_last flags.
- S2 register:
  - re = arbr − aibi, im = arbi + aibr, each 2·WIDTH+1 bits.
  - acc_en=0: the stage value is the sum itself and is emitted.
  - acc_en=1: sum is added to the accumulator (2·WIDTH+1+GUARD bits). The term counter increments.
  - The accumulated value is emitted when acc_last=1 or the counter reaches 2^GUARD. Reaching 2^GUARD without acc_last sets out_forced.
  - On emit, the accumulator and counter clear so the next beat starts fresh. Non-emitting burst beats produce no output.
- S3 register, formatting per component x:
  - ROUND=0: arithmetic shift x>>>FRAC. Add 1 if x<0 and any dropped bit is nonzero (truncate toward zero).
  - ROUND=1: x≥0 → (x + 2^(FRAC-1))>>>FRAC; x<0 → (x + 2^(FRAC-1) − 1)>>>FRAC.
  - Saturation: if the shifted value exceeds 2^(WIDTH-1)−1, clamp to it; if below −2^(WIDTH-1), clamp to it. Set out_sat if either component clamps.
- Flow control: en = !out_valid || out_ready. All stages advance only when en=1. in_ready = en (combinational from out_ready). Bubbles propagate as valid=0.
- acc_en=0 beat arriving mid-burst: the burst accumulation is not disturbed, and the beat emits its own product independently.
- Reset (any time, including mid-burst or mid-stall):
  - Pipeline valids, accumulator, counter, out_valid, out_re, out_im, out_sat, and out_forced all clear to 0.
  - The partial burst is discarded.

## Timing
- Latency: a beat accepted at edge k (no stall) gives out_valid=1 after edge k+3.
- Throughput: one beat per cycle.
- Burst: an N-term burst produces exactly one output, 3 cycles after the acc_last beat.
- Stall: while out_valid && !out_ready, out_re, out_im, out_sat, and out_forced stay stable. in_ready=0 and no internal state changes.
- Release: out_ready=1 together with in_valid=1 on the same edge both drains and accepts.
- Reset: all outputs are 0 while rst_n=0. in_ready=1 after reset release.

## Test plan
- Basic multiply, WIDTH=13, FRAC=8, ROUND=0:
  - (384,128)×(256,−256) → (512,−256), out_valid exactly 3 cycles after accept.
  - Same operands with conj_b=1 → (256,512).
- Rounding: (−128,0)×(1,0) → out_re 0 with ROUND=0, −1 with ROUND=1. (384,0)×(1,0) → 1 with ROUND=0, 2 with ROUND=1.
- Saturation:
  - (4095,0)×(4095,0) → (4095,0), out_sat=1.
  - (−4096,0)×(4095,0) → (−4096,0), out_sat=1.
  - conj_b=1 with b_im=−4096 → no wrap.
- Accumulate: 4 beats of (256,0)×(256,0), acc_en=1, acc_last on beat 4 → single output (1024,0), out_forced=0. Then 16 beats with no acc_last (GUARD=4) → output after beat 16 with out_forced=1, then the accumulator is clear.
- Backpressure: stream 8 beats, hold out_ready=0 for 5 cycles mid-stream → in_ready=0 throughout, outputs stable, all 8 results appear in order with none lost or duplicated.
- Reset mid-burst: 2 burst beats, assert rst_n=0 asynchronously for 1 cycle → outputs zero immediately. A following 1-beat burst (256,0)×(256,0) with acc_last returns (256,0).
